// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: passes ALU results through and runs load/store data-bus transactions
// with big-endian lane selection, load extension, an alignment check and a bus watchdog.
module mem_access_ctrl #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic [4:0]  wb_wd_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        stallreq_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_sel_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = 10;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wdog_q, wdog_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               abort_q, abort_d;
    logic               launch;

    // Bus attributes latched on entry to BUS so they stay constant for the whole transfer
    logic               we_q;
    logic [3:0]         sel_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         op_q;
    logic [1:0]         off_q;

    logic               is_load_c, is_store_c, is_mem_c, misalign_c, op_q_load_c;
    logic [3:0]         sel_c;
    logic [31:0]        st_wdata_c;

    // Lane pick then sign/zero extension of the returned bus word
    function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = r[31:24];
            2'd1:    b = r[23:16];
            2'd2:    b = r[15:8];
            default: b = r[7:0];
        endcase
        h = off[1] ? r[15:0] : r[31:16];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'd0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'd0, h};
            OP_LW:   load_ext = r;
            default: load_ext = 32'd0;
        endcase
    endfunction

    // Decode of the op currently presented by EX/MEM
    always_comb begin
        is_load_c   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
        is_store_c  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        is_mem_c    = is_load_c || is_store_c;
        op_q_load_c = (op_q >= OP_LB) && (op_q <= OP_LW);
        misalign_c  = 1'b0;
        sel_c       = 4'b0000;
        st_wdata_c  = 32'd0;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                sel_c = 4'b1000 >> mem_addr_i[1:0];
            end
            OP_LH, OP_LHU, OP_SH: begin
                misalign_c = mem_addr_i[0];
                sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW, OP_SW: begin
                misalign_c = (mem_addr_i[1:0] != 2'b00);
                sel_c      = 4'b1111;
            end
            default: ;
        endcase
        case (mem_op_i)
            OP_SB:   st_wdata_c = {4{mem_sdata_i[7:0]}};
            OP_SH:   st_wdata_c = {2{mem_sdata_i[15:0]}};
            OP_SW:   st_wdata_c = mem_sdata_i;
            default: st_wdata_c = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wdog_q  <= '0;
            rdata_q <= 32'd0;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            op_q    <= 4'd0;
            off_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
            if (launch) begin
                we_q    <= is_store_c;
                sel_q   <= sel_c;
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                wdata_q <= st_wdata_c;
                op_q    <= mem_op_i;
                off_q   <= mem_addr_i[1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        rdata_d      = rdata_q;
        abort_d      = abort_q;
        launch       = 1'b0;
        wb_wd_o      = 5'd0;
        wb_wreg_o    = 1'b0;
        wb_wdata_o   = 32'd0;
        stallreq_o   = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = 32'd0;
        dbus_sel_o   = 4'd0;
        dbus_wdata_o = 32'd0;
        addr_err_o   = 1'b0;
        bus_err_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (!is_mem_c) begin
                    wb_wd_o    = mem_wd_i;
                    wb_wreg_o  = mem_wreg_i;
                    wb_wdata_o = mem_wdata_i;
                end else if (misalign_c) begin
                    wb_wd_o    = mem_wd_i;
                    addr_err_o = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                    launch     = 1'b1;
                    abort_d    = 1'b0;
                    rdata_d    = 32'd0;
                    state_d    = ST_BUS;
                end
            end
            ST_BUS: begin
                stallreq_o   = 1'b1;
                dbus_req_o   = 1'b1;
                dbus_we_o    = we_q;
                dbus_addr_o  = addr_q;
                dbus_sel_o   = sel_q;
                dbus_wdata_o = wdata_q;
                wdog_d       = wdog_q + CNT_W'(1);
                // Ack takes priority over a watchdog expiry in the same cycle
                if (dbus_ack_i) begin
                    rdata_d = op_q_load_c ? load_ext(op_q, off_q, dbus_rdata_i) : 32'd0;
                    abort_d = 1'b0;
                    state_d = ST_DONE;
                end else if (wdog_q == CNT_W'(BUS_TIMEOUT - 1)) begin
                    rdata_d = 32'd0;
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_wd_o    = mem_wd_i;
                wb_wreg_o  = mem_wreg_i && op_q_load_c && !abort_q;
                wb_wdata_o = rdata_q;
                bus_err_o  = abort_q;
                wdog_d     = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs read as idle while reset is asserted
        if (rst) begin
            launch       = 1'b0;
            wb_wd_o      = 5'd0;
            wb_wreg_o    = 1'b0;
            wb_wdata_o   = 32'd0;
            stallreq_o   = 1'b0;
            dbus_req_o   = 1'b0;
            dbus_we_o    = 1'b0;
            dbus_addr_o  = 32'd0;
            dbus_sel_o   = 4'd0;
            dbus_wdata_o = 32'd0;
            addr_err_o   = 1'b0;
            bus_err_o    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops push expected retire/bus records,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        stallreq_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_sel_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        addr_err_o;
    logic        bus_err_o;

    mem_access_ctrl #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .stallreq_o(stallreq_o),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
        .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        aerr;
        logic        berr;
        int          stall;
        int          req;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    int ack_lat = 0;
    logic slave_ack = 1'b0;
    logic late_ack = 1'b0;
    logic [31:0] slave_rdata = 32'd0;

    assign dbus_ack_i   = slave_ack | late_ack;
    assign dbus_rdata_i = slave_rdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave acks in the ack_lat-th cycle of a request; ack_lat=0 never acks
    int slave_cnt = 0;
    always @(negedge clk) begin
        if (dbus_req_o) begin
            slave_cnt = slave_cnt + 1;
            slave_ack = (ack_lat != 0) && (slave_cnt == ack_lat);
        end else begin
            slave_cnt = 0;
            slave_ack = 1'b0;
        end
    end

    // Monitor: bus record on the first request cycle, retire record whenever the stage is not stalled
    int   stall_cnt = 0;
    int   req_cnt = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (!mon_en || rst) begin
            stall_cnt = 0;
            req_cnt   = 0;
            req_prev  = 1'b0;
        end else begin
            if (dbus_req_o && !req_prev) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected", 1, 0);
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    chk("bus_we", dbus_we_o, b.we);
                    chk("bus_addr", dbus_addr_o, b.addr);
                    chk("bus_sel", dbus_sel_o, b.sel);
                    chk("bus_wdata", dbus_wdata_o, b.wdata);
                end
            end
            if (!dbus_req_o)
                chk("bus_idle_zero", {dbus_we_o, dbus_sel_o, dbus_addr_o, dbus_wdata_o}, 0);
            req_prev = dbus_req_o;
            if (stallreq_o) stall_cnt = stall_cnt + 1;
            if (dbus_req_o) req_cnt = req_cnt + 1;
            if (!stallreq_o) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 1, 0);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_wd", wb_wd_o, e.wd);
                    chk("wb_wreg", wb_wreg_o, e.wreg);
                    chk("wb_wdata", wb_wdata_o, e.wdata);
                    chk("addr_err", addr_err_o, e.aerr);
                    chk("bus_err", bus_err_o, e.berr);
                    chk("stall_cycles", stall_cnt, e.stall);
                    chk("req_cycles", req_cnt, e.req);
                end
                stall_cnt = 0;
                req_cnt   = 0;
            end
        end
    end

    // Present one EX/MEM instruction, push its expectations, hold it until the stage releases it
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input int lat, input logic [31:0] rd,
                         input logic [31:0] exp_wdata, input logic exp_wreg,
                         input logic aerr, input logic berr, input int nbus,
                         input logic [3:0] exp_sel, input logic [31:0] exp_bwdata);
        wb_exp_t  e;
        bus_exp_t b;
        int cyc;
        mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
        mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = wdata;
        ack_lat = lat; slave_rdata = rd;
        e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_wdata; e.aerr = aerr; e.berr = berr;
        e.stall = (nbus > 0) ? nbus + 1 : 0;
        e.req = nbus;
        wb_q.push_back(e);
        if (nbus > 0) begin
            b.we = (op >= 4'd6) && (op <= 4'd8);
            b.addr = {addr[31:2], 2'b00};
            b.sel = exp_sel;
            b.wdata = exp_bwdata;
            bus_q.push_back(b);
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (stallreq_o && cyc < 50);
        if (stallreq_o) chk("issue_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_op_i = 4'd0; mem_addr_i = 32'h104; mem_sdata_i = 32'hFFFF_FFFF;
        mem_wd_i = 5'd5; mem_wreg_i = 1'b1; mem_wdata_i = 32'h1234;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_wb", {wb_wd_o, wb_wreg_o, wb_wdata_o}, 0);
        chk("rst_ctl", {stallreq_o, dbus_req_o, addr_err_o, bus_err_o}, 0);
        chk("rst_bus", {dbus_we_o, dbus_sel_o, dbus_addr_o, dbus_wdata_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        //    op     addr          sdata         wd  wr data         lat rdata         exp_wdata     ew ae be n  sel      bus wdata
        issue(4'd0,  32'h0,        32'h0,        5,  1, 32'h1234,     0, 32'h0,        32'h1234,     1, 0, 0, 0, 4'b0000, 32'h0);
        issue(4'd1,  32'h101,      32'h0,        3,  1, 32'hAAAA,     2, 32'h11A23344, 32'hFFFFFFA2, 1, 0, 0, 2, 4'b0100, 32'h0);
        issue(4'd2,  32'h101,      32'h0,        3,  1, 32'hAAAA,     2, 32'h11A23344, 32'h000000A2, 1, 0, 0, 2, 4'b0100, 32'h0);
        issue(4'd7,  32'h202,      32'hDEADBEEF, 7,  1, 32'h55,       1, 32'h99999999, 32'h0,        0, 0, 0, 1, 4'b0011, 32'hBEEFBEEF);
        issue(4'd5,  32'h6,        32'h0,        9,  1, 32'h77,       0, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
        issue(4'd5,  32'h40,       32'h0,        10, 1, 32'h77,       0, 32'h12345678, 32'h0,        0, 0, 1, 4, 4'b1111, 32'h0);
        issue(4'd0,  32'h40,       32'h0,        11, 1, 32'hABCD,     0, 32'h0,        32'hABCD,     1, 0, 0, 0, 4'b0000, 32'h0);
        issue(4'd5,  32'h8,        32'h0,        12, 1, 32'h0,        4, 32'h01020304, 32'h01020304, 1, 0, 0, 4, 4'b1111, 32'h0);
        issue(4'd3,  32'h102,      32'h0,        13, 1, 32'h0,        1, 32'h11A28344, 32'hFFFF8344, 1, 0, 0, 1, 4'b0011, 32'h0);
        issue(4'd4,  32'h100,      32'h0,        14, 1, 32'h0,        1, 32'h11A28344, 32'h000011A2, 1, 0, 0, 1, 4'b1100, 32'h0);
        issue(4'd5,  32'h104,      32'h0,        15, 1, 32'h0,        3, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0, 0, 3, 4'b1111, 32'h0);
        issue(4'd6,  32'h303,      32'h12345678, 16, 1, 32'h0,        2, 32'h0,        32'h0,        0, 0, 0, 2, 4'b0001, 32'h78787878);
        issue(4'd8,  32'h400,      32'h0BADF00D, 17, 1, 32'h0,        1, 32'h0,        32'h0,        0, 0, 0, 1, 4'b1111, 32'h0BADF00D);
        issue(4'd1,  32'h103,      32'h0,        18, 1, 32'h0,        1, 32'h11A23344, 32'h00000044, 1, 0, 0, 1, 4'b0001, 32'h0);
        issue(4'd1,  32'h100,      32'h0,        19, 1, 32'h0,        1, 32'h80000000, 32'hFFFFFF80, 1, 0, 0, 1, 4'b1000, 32'h0);
        issue(4'd7,  32'h201,      32'h1111,     20, 1, 32'h0,        1, 32'h0,        32'h0,        0, 1, 0, 0, 4'b0000, 32'h0);
        issue(4'd3,  32'h100,      32'h0,        21, 0, 32'h0,        1, 32'h8000FFFF, 32'hFFFF8000, 0, 0, 0, 1, 4'b1100, 32'h0);
        issue(4'd12, 32'h3,        32'h0,        22, 1, 32'hFEED,     0, 32'h0,        32'hFEED,     1, 0, 0, 0, 4'b0000, 32'h0);

        // Reset during the second BUS cycle of a never-acked LW, then a stray late ack
        mon_en = 1'b0;
        mem_op_i = 4'd5; mem_addr_i = 32'h10; mem_wd_i = 5'd4; mem_wreg_i = 1'b1;
        ack_lat = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_pre_req", dbus_req_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctl", {stallreq_o, dbus_req_o, addr_err_o, bus_err_o}, 0);
        chk("rst_mid_wb", {wb_wd_o, wb_wreg_o, wb_wdata_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_op_i = 4'd0; mem_addr_i = 32'h0; mem_sdata_i = 32'h0;
        mem_wd_i = 5'd0; mem_wreg_i = 1'b0; mem_wdata_i = 32'h0;
        late_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_ctl", {stallreq_o, dbus_req_o, addr_err_o, bus_err_o}, 0);
            chk("post_rst_wb", {wb_wd_o, wb_wreg_o, wb_wdata_o}, 0);
            chk("post_rst_bus", {dbus_we_o, dbus_sel_o, dbus_addr_o, dbus_wdata_o}, 0);
            @(posedge clk); #1;
        end
        late_ack = 1'b0;
        mon_en = 1'b1;
        issue(4'd0,  32'h0,        32'h0,        23, 1, 32'h5A5A,     0, 32'h0,        32'h5A5A,     1, 0, 0, 0, 4'b0000, 32'h0);
        issue(4'd5,  32'h20,       32'h0,        24, 1, 32'h0,        1, 32'h13579BDF, 32'h13579BDF, 1, 0, 0, 1, 4'b1111, 32'h0);

        @(negedge clk);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
